// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : state encodings and owner constants shared by the arbiter
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_grant2.sv
// ============================================================================
// rr_grant2 : two-way round-robin winner select with bounded lock retention
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_grant2
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       grant_i,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  input  logic       last_owner_i,
  output logic       winner_o
);

  localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_BURST);

  logic [CNT_W-1:0] r_burst_cnt;
  logic [CNT_W-1:0] w_next_cnt;
  logic             w_winner;
  logic             w_keep;

  // The previous owner keeps the bus only while its lock budget lasts.
  assign w_keep = lock_i[last_owner_i] && (r_burst_cnt < c_max_cnt);

  always_comb begin
    w_winner = last_owner_i;
    if (req_i == 2'b01) begin
      w_winner = OWN_M0;
    end else if (req_i == 2'b10) begin
      w_winner = OWN_M1;
    end else if (req_i == 2'b11) begin
      w_winner = w_keep ? last_owner_i : ~last_owner_i;
    end

    w_next_cnt = r_burst_cnt;
    if (w_winner != last_owner_i) begin
      w_next_cnt = CNT_W'(1);
    end else if (r_burst_cnt < c_max_cnt) begin
      w_next_cnt = r_burst_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_burst_cnt <= '0;
    end else if (grant_i) begin
      r_burst_cnt <= w_next_cnt;
    end
  end

  assign winner_o = w_winner;

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : shares the single-port main bram between CPU (m0) and DMA (m1)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 13,
  parameter int MAX_BURST = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_req_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [3:0]        m0_we_i,
  input  logic [31:0]       m0_data_i,
  input  logic              m0_lock_i,
  output logic              m0_ack_o,
  output logic [31:0]       m0_data_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [3:0]        m1_we_i,
  input  logic [31:0]       m1_data_i,
  input  logic              m1_lock_i,
  output logic              m1_ack_o,
  output logic [31:0]       m1_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_cs_n_o,
  output logic [3:0]        mem_we_n_o,
  output logic [31:0]       mem_data_o,
  input  logic [31:0]       mem_data_i,
  output logic              owner_o,
  output logic              busy_o
);

  arb_state_t r_state;
  logic       r_owner;
  logic       w_grant;
  logic       w_winner;

  assign w_grant = (r_state == IDLE) && (m0_req_i || m1_req_i);

  rr_grant2 #(
    .MAX_BURST (MAX_BURST)
  ) u_grant (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .grant_i      (w_grant),
    .req_i        ({m1_req_i, m0_req_i}),
    .lock_i       ({m1_lock_i, m0_lock_i}),
    .last_owner_i (r_owner),
    .winner_o     (w_winner)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_owner <= OWN_M1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner <= w_winner;
            r_state <= ISSUE;
          end
        end
        ISSUE:   r_state <= RESP;
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Bram side is driven straight from the held master inputs during ISSUE;
  // read data is forwarded during RESP, matching the 1-cycle bram latency.
  always_comb begin
    mem_cs_n_o = 1'b1;
    mem_we_n_o = 4'hF;
    mem_addr_o = '0;
    mem_data_o = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_data_o  = '0;
    m1_data_o  = '0;
    if (r_state == ISSUE) begin
      mem_cs_n_o = 1'b0;
      mem_addr_o = (r_owner == OWN_M1) ? m1_addr_i : m0_addr_i;
      mem_we_n_o = (r_owner == OWN_M1) ? ~m1_we_i : ~m0_we_i;
      mem_data_o = (r_owner == OWN_M1) ? m1_data_i : m0_data_i;
    end else if (r_state == RESP) begin
      if (r_owner == OWN_M1) begin
        m1_ack_o  = 1'b1;
        m1_data_o = mem_data_i;
      end else begin
        m0_ack_o  = 1'b1;
        m0_data_o = mem_data_i;
      end
    end
  end

  assign owner_o = r_owner;
  assign busy_o  = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : directed stimulus with queue-based scoreboard for ram_arbiter
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  localparam int ADDR_W    = 13;
  localparam int MAX_BURST = 4;

  logic              clk;
  logic              rst;
  logic              m0_req, m1_req, m0_lock, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [3:0]        m0_we, m1_we;
  logic [31:0]       m0_wdata, m1_wdata;
  logic              m0_ack, m1_ack;
  logic [31:0]       m0_rdata, m1_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_cs_n;
  logic [3:0]        mem_we_n;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              owner, busy;

  logic              pl_en;
  logic [ADDR_W-1:0] pl_addr;
  logic [31:0]       pl_data;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  typedef struct packed {
    logic              master;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        we_n;
    logic [31:0]       wdata;
  } iss_t;

  typedef struct packed {
    logic        master;
    logic [31:0] rdata;
  } ack_t;

  iss_t iss_q[$];
  ack_t ack_q[$];

  int vectors     = 0;
  int miscompares = 0;
  int ack_total   = 0;

  ram_arbiter #(
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .m0_req_i   (m0_req),
    .m0_addr_i  (m0_addr),
    .m0_we_i    (m0_we),
    .m0_data_i  (m0_wdata),
    .m0_lock_i  (m0_lock),
    .m0_ack_o   (m0_ack),
    .m0_data_o  (m0_rdata),
    .m1_req_i   (m1_req),
    .m1_addr_i  (m1_addr),
    .m1_we_i    (m1_we),
    .m1_data_i  (m1_wdata),
    .m1_lock_i  (m1_lock),
    .m1_ack_o   (m1_ack),
    .m1_data_o  (m1_rdata),
    .mem_addr_o (mem_addr),
    .mem_cs_n_o (mem_cs_n),
    .mem_we_n_o (mem_we_n),
    .mem_data_o (mem_wdata),
    .mem_data_i (mem_rdata),
    .owner_o    (owner),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first bram model with a preload port.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (mem_cs_n == 1'b0) begin
      mem_rdata <= mem[mem_addr];
      for (int b = 0; b < 4; b++) begin
        if (!mem_we_n[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Monitor: pops expected issue/ack entries whenever the DUT presents them.
  always @(negedge clk) begin
    iss_t e;
    ack_t a;
    if (mem_cs_n === 1'b0) begin
      if (iss_q.size() == 0) begin
        flag("unexpected_issue");
      end else begin
        e = iss_q.pop_front();
        check("issue_owner", {31'd0, owner}, {31'd0, e.master});
        check("issue_addr", {19'd0, mem_addr}, {19'd0, e.addr});
        check("issue_we_n", {28'd0, mem_we_n}, {28'd0, e.we_n});
        check("issue_wdata", mem_wdata, e.wdata);
      end
    end else if (busy === 1'b1) begin
      check("resp_we_n", {28'd0, mem_we_n}, 32'hF);
    end
    if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
      ack_total++;
      check("one_ack", {31'd0, m0_ack & m1_ack}, 32'd0);
      if (ack_q.size() == 0) begin
        flag("unexpected_ack");
      end else begin
        a = ack_q.pop_front();
        check("ack_master", {31'd0, m1_ack}, {31'd0, a.master});
        check("ack_data", a.master ? m1_rdata : m0_rdata, a.rdata);
        check("other_data_zero", a.master ? m0_rdata : m1_rdata, 32'd0);
      end
    end
  end

  task automatic push_acc(input logic m, input logic [ADDR_W-1:0] ad, input logic [3:0] we,
                          input logic [31:0] wd, input logic [31:0] rd);
    iss_t e;
    ack_t a;
    e.master = m; e.addr = ad; e.we_n = ~we; e.wdata = wd;
    a.master = m; a.rdata = rd;
    iss_q.push_back(e);
    ack_q.push_back(a);
  endtask

  task automatic drive(input logic m, input logic req, input logic [ADDR_W-1:0] ad,
                       input logic [3:0] we, input logic [31:0] wd);
    if (m) begin
      m1_req = req; m1_addr = ad; m1_we = we; m1_wdata = wd;
    end else begin
      m0_req = req; m0_addr = ad; m0_we = we; m0_wdata = wd;
    end
  endtask

  task automatic single_access(input logic m, input logic [ADDR_W-1:0] ad, input logic [3:0] we,
                               input logic [31:0] wd, input logic [31:0] rd);
    push_acc(m, ad, we, wd, rd);
    drive(m, 1'b1, ad, we, wd);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("ack_latency", {31'd0, m ? m1_ack : m0_ack}, 32'd1);
    drive(m, 1'b0, '0, 4'h0, 32'd0);
    @(negedge clk);
  endtask

  task automatic wait_acks(input int target);
    for (int n = 0; n < 200 && ack_total < target; n++) begin
      @(negedge clk);
      #1;
    end
    if (ack_total < target) check("ack_timeout", ack_total, target);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    m0_req = 1'b0; m1_req = 1'b0; m0_lock = 1'b0; m1_lock = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] ad, input logic [31:0] d);
    pl_addr = ad; pl_data = d; pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    iss_t e;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    m0_req = 0; m0_addr = '0; m0_we = '0; m0_wdata = '0; m0_lock = 0;
    m1_req = 0; m1_addr = '0; m1_we = '0; m1_wdata = '0; m1_lock = 0;
    @(negedge clk);
    preload(13'h010, 32'hDEADBEEF);
    preload(13'h1FF, 32'hAABBCCDD);
    preload(13'h020, 32'h0A0A0A0A);
    preload(13'h030, 32'h1B1B1B1B);
    preload(13'h040, 32'h00000000);

    check("rst_cs_n", {31'd0, mem_cs_n}, 32'd1);
    check("rst_we_n", {28'd0, mem_we_n}, 32'hF);
    check("rst_addr", {19'd0, mem_addr}, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
    check("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
    check("rst_m0_data", m0_rdata, 32'd0);
    check("rst_m1_data", m1_rdata, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic read, byte-masked write, and readback of the merged word.
    single_access(1'b0, 13'h010, 4'b0000, 32'd0, 32'hDEADBEEF);
    single_access(1'b1, 13'h1FF, 4'b0011, 32'h12345678, 32'hAABBCCDD);
    single_access(1'b0, 13'h1FF, 4'b0000, 32'd0, 32'hAABB5678);

    // Both masters requesting, no lock: strict alternation starting at m0.
    do_reset();
    drive(1'b0, 1'b0, 13'h020, 4'h0, 32'h11111111);
    drive(1'b1, 1'b0, 13'h030, 4'h0, 32'h22222222);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) push_acc(1'b0, 13'h020, 4'h0, 32'h11111111, 32'h0A0A0A0A);
      else            push_acc(1'b1, 13'h030, 4'h0, 32'h22222222, 32'h1B1B1B1B);
    end
    base = ack_total;
    m0_req = 1'b1; m1_req = 1'b1;
    wait_acks(base + 4);
    m0_req = 1'b0; m1_req = 1'b0;

    // m1 locking against a requesting m0: four m1 grants, then m0, then m1.
    do_reset();
    m1_lock = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) push_acc(1'b0, 13'h020, 4'h0, 32'h11111111, 32'h0A0A0A0A);
      else        push_acc(1'b1, 13'h030, 4'h0, 32'h22222222, 32'h1B1B1B1B);
    end
    base = ack_total;
    m0_req = 1'b1; m1_req = 1'b1;
    wait_acks(base + 6);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;

    // m1 locked alone beyond saturation, then m0 joins and wins next.
    do_reset();
    m1_lock = 1'b1;
    for (int i = 0; i < 6; i++) push_acc(1'b1, 13'h030, 4'h0, 32'h22222222, 32'h1B1B1B1B);
    push_acc(1'b0, 13'h020, 4'h0, 32'h11111111, 32'h0A0A0A0A);
    push_acc(1'b1, 13'h030, 4'h0, 32'h22222222, 32'h1B1B1B1B);
    base = ack_total;
    m1_req = 1'b1;
    wait_acks(base + 6);
    m0_req = 1'b1;
    wait_acks(base + 8);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;

    // Reset during ISSUE of an m0 write: ack lost, re-request completes.
    do_reset();
    e.master = 1'b0; e.addr = 13'h040; e.we_n = 4'h0; e.wdata = 32'hCAFEF00D;
    iss_q.push_back(e);
    drive(1'b0, 1'b1, 13'h040, 4'hF, 32'hCAFEF00D);
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_cs_n", {31'd0, mem_cs_n}, 32'd1);
    check("rstmid_ack", {31'd0, m0_ack}, 32'd0);
    rst = 1'b0;
    push_acc(1'b0, 13'h040, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rerequest_ack", {31'd0, m0_ack}, 32'd1);
    drive(1'b0, 1'b0, '0, 4'h0, 32'd0);
    @(negedge clk);
    single_access(1'b0, 13'h040, 4'h0, 32'd0, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    #1;
    check("iss_q_drained", iss_q.size(), 32'd0);
    check("ack_q_drained", ack_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
